loop_uhat_sparse_mac_pipe: RTL and testbench

LOOP_UHAT_SPARSE_MAC_PIPE -- requirements
Module: loop_uhat_sparse_mac_pipe

---
 rtl/loop_uhat_sparse_pkg.sv | 21 ++
 rtl/loop_uhat_sparse_delay_line.sv | 35 +++
 rtl/loop_uhat_sparse_mac_pipe.sv | 151 +++++++++++++++
 tb/tb_loop_uhat_sparse_mac_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_uhat_sparse_pkg.sv
// Shared constants and saturation bounds for the sparse MAC pipeline.
// Saturation is enabled by defining LOOP_UHAT_SPARSE_MAC_SAT_EN.
package loop_uhat_sparse_pkg;

  localparam int DEF_DIN0_W   = 14;
  localparam int DEF_DIN1_W   = 12;
  localparam int DEF_DOUT_W   = 26;
  localparam int DEF_STAGES   = 4;
  localparam int MIN_STAGES   = 2;
  localparam int MAX_STAGES   = 8;

  // Bounds returned in 64 bits; callers keep the low w bits.
  function automatic logic [63:0] sat_max(input int w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    sat_min = ~sat_max(w);
  endfunction

endpackage

// File: rtl/loop_uhat_sparse_delay_line.sv
// ce-gated shift register with async active-low clear.
// DEPTH of 0 degenerates to a wire.
module loop_uhat_sparse_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] r_sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++)
            r_sr[i] <= '0;
        end else if (ce) begin
          r_sr[0] <= d;
          for (int i = 1; i < DEPTH; i++)
            r_sr[i] <= r_sr[i-1];
        end
      end

      assign q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/loop_uhat_sparse_mac_pipe.sv
// Pipelined multiply / multiply-accumulate, NUM_STAGE ce-cycle latency.
// Define LOOP_UHAT_SPARSE_MAC_SAT_EN for saturating accumulation.
module loop_uhat_sparse_mac_pipe
  import loop_uhat_sparse_pkg::*;
#(
  parameter int DIN0_WIDTH  = DEF_DIN0_W,
  parameter int DIN1_WIDTH  = DEF_DIN1_W,
  parameter int DOUT_WIDTH  = DEF_DOUT_W,
  parameter int NUM_STAGE   = DEF_STAGES,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_mode,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  sat_flag
);

  localparam int DLY = NUM_STAGE - 2;

  logic [DIN0_WIDTH-1:0] r_a;
  logic [DIN1_WIDTH-1:0] r_b;
  logic                  r_v;
  logic                  r_f;
  logic                  r_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
      r_v <= 1'b0;
      r_f <= 1'b0;
      r_l <= 1'b0;
    end else if (ce) begin
      r_a <= din0;
      r_b <= din1;
      r_v <= in_valid;
      r_f <= in_first;
      r_l <= in_last;
    end
  end

  logic signed [DIN0_WIDTH:0] w_a_ext;
  logic signed [DIN1_WIDTH:0] w_b_ext;
  logic [DOUT_WIDTH-1:0]      w_prod;

  assign w_a_ext = {(DIN0_SIGNED != 0) & r_a[DIN0_WIDTH-1], r_a};
  assign w_b_ext = {(DIN1_SIGNED != 0) & r_b[DIN1_WIDTH-1], r_b};

  // Multiplying at DOUT_WIDTH gives the sign-extended or low-truncated product.
  assign w_prod = DOUT_WIDTH'(w_a_ext) * DOUT_WIDTH'(w_b_ext);

  logic [2:0]            w_ctrl;
  logic [DOUT_WIDTH-1:0] w_p;
  logic                  w_v;
  logic                  w_f;
  logic                  w_l;

  loop_uhat_sparse_delay_line #(
    .WIDTH (3),
    .DEPTH (DLY)
  ) u_ctrl_dly (
    .clk   (clk),
    .rst_n (reset),
    .ce    (ce),
    .d     ({r_v, r_f, r_l}),
    .q     (w_ctrl)
  );

  loop_uhat_sparse_delay_line #(
    .WIDTH (DOUT_WIDTH),
    .DEPTH (DLY)
  ) u_data_dly (
    .clk   (clk),
    .rst_n (reset),
    .ce    (ce),
    .d     (w_prod),
    .q     (w_p)
  );

  assign {w_v, w_f, w_l} = w_ctrl;

  logic [DOUT_WIDTH-1:0] r_dout;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DOUT_WIDTH-1:0] w_acc_next;

`ifdef LOOP_UHAT_SPARSE_MAC_SAT_EN
  logic signed [DOUT_WIDTH:0] w_sum;
  logic                       w_ovf;
  logic                       r_sat;

  assign w_sum = {r_dout[DOUT_WIDTH-1], r_dout} + {w_p[DOUT_WIDTH-1], w_p};
  assign w_ovf = w_sum[DOUT_WIDTH] ^ w_sum[DOUT_WIDTH-1];

  always_comb begin
    w_acc_next = w_sum[DOUT_WIDTH-1:0];
    if (w_ovf)
      w_acc_next = w_sum[DOUT_WIDTH] ? DOUT_WIDTH'(sat_min(DOUT_WIDTH))
                                     : DOUT_WIDTH'(sat_max(DOUT_WIDTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_sat <= 1'b0;
    else if (ce && w_v) begin
      if (w_f)
        r_sat <= 1'b0;
      else if (acc_mode && w_ovf)
        r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  assign w_acc_next = r_dout + w_p;
  assign sat_flag   = 1'b0;
`endif

  // Bubbles keep dout, which doubles as the accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_v;
      r_out_last  <= w_v & w_l;
      if (w_v) begin
        if (!acc_mode || w_f)
          r_dout <= w_p;
        else
          r_dout <= w_acc_next;
      end
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_loop_uhat_sparse_mac_pipe.sv
// Directed self-checking bench for loop_uhat_sparse_mac_pipe.
// Covers default, 16-bit, 2-stage and 8-stage builds.
module tb_loop_uhat_sparse_mac_pipe;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [13:0] din0;
  logic [11:0] din1;
  logic        acc_mode;
  logic        in_first;
  logic        in_last;

  logic [25:0] d0_dout;
  logic        d0_vld, d0_last, d0_sat;
  logic [15:0] d16_dout;
  logic        d16_vld, d16_last, d16_sat;
  logic [25:0] s2_dout;
  logic        s2_vld, s2_last, s2_sat;
  logic [25:0] s8_dout;
  logic        s8_vld, s8_last, s8_sat;

  int n_checks = 0;
  int n_errors = 0;

  loop_uhat_sparse_mac_pipe u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_mode(acc_mode),
    .in_first(in_first), .in_last(in_last),
    .dout(d0_dout), .out_valid(d0_vld), .out_last(d0_last),
    .sat_flag(d0_sat)
  );

  loop_uhat_sparse_mac_pipe #(.DOUT_WIDTH(16)) u_d16 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_mode(acc_mode),
    .in_first(in_first), .in_last(in_last),
    .dout(d16_dout), .out_valid(d16_vld), .out_last(d16_last),
    .sat_flag(d16_sat)
  );

  loop_uhat_sparse_mac_pipe #(.NUM_STAGE(2), .DIN1_SIGNED(1)) u_s2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_mode(acc_mode),
    .in_first(in_first), .in_last(in_last),
    .dout(s2_dout), .out_valid(s2_vld), .out_last(s2_last),
    .sat_flag(s2_sat)
  );

  loop_uhat_sparse_mac_pipe #(.NUM_STAGE(8), .DIN1_SIGNED(1)) u_s8 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_mode(acc_mode),
    .in_first(in_first), .in_last(in_last),
    .dout(s8_dout), .out_valid(s8_vld), .out_last(s8_last),
    .sat_flag(s8_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic put(input logic [13:0] a, input logic [11:0] b,
                     input logic f, input logic l);
    din0     = a;
    din1     = b;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  longint exp16;
  longint exp16_sat;

  initial begin
    reset    = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    din0     = '0;
    din1     = '0;
    acc_mode = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("rst_dout", longint'(d0_dout), 0);
    chk("rst_vld", longint'(d0_vld), 0);
    chk("rst_last", longint'(d0_last), 0);
    chk("rst_sat", longint'(d0_sat), 0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // multiply-only latency and sign handling
    acc_mode = 1'b0;
    put(14'h3FFD, 12'hFFF, 1'b0, 1'b0);
    step();
    step();
    chk("mul_early_vld", longint'(d0_vld), 0);
    step();
    chk("mul_vld", longint'(d0_vld), 1);
    chk("mul_dout", longint'($signed(d0_dout)), -12285);
    chk("mul_last", longint'(d0_last), 0);

    // accumulation group
    idle(10);
    acc_mode = 1'b1;
    put(14'd2, 12'd3, 1'b1, 1'b0);
    put(14'd4, 12'd5, 1'b0, 1'b0);
    put(14'h3FFF, 12'd6, 1'b0, 1'b1);
    step();
    chk("acc_b1_vld", longint'(d0_vld), 1);
    chk("acc_b1_dout", longint'($signed(d0_dout)), 6);
    chk("acc_b1_last", longint'(d0_last), 0);
    step();
    chk("acc_b2_dout", longint'($signed(d0_dout)), 26);
    step();
    chk("acc_b3_dout", longint'($signed(d0_dout)), 20);
    chk("acc_b3_last", longint'(d0_last), 1);
    step();
    chk("acc_bub_vld", longint'(d0_vld), 0);
    chk("acc_bub_dout", longint'($signed(d0_dout)), 20);

    // first and last on the same beat
    put(14'd7, 12'd3, 1'b1, 1'b1);
    idle(3);
    chk("single_dout", longint'($signed(d0_dout)), 21);
    chk("single_last", longint'(d0_last), 1);

    // clock-enable stalls
    idle(10);
    acc_mode = 1'b0;
    put(14'd3, 12'd4, 1'b0, 1'b0);
    put(14'd5, 12'd6, 1'b0, 1'b0);
    ce = 1'b0;
    idle(3);
    chk("ce_frz_vld", longint'(d0_vld), 0);
    chk("ce_frz_dout", longint'($signed(d0_dout)), 21);
    ce = 1'b1;
    step();
    chk("ce_a_early", longint'(d0_vld), 0);
    step();
    chk("ce_a_vld", longint'(d0_vld), 1);
    chk("ce_a_dout", longint'($signed(d0_dout)), 12);
    ce = 1'b0;
    idle(2);
    chk("ce_hold_vld", longint'(d0_vld), 1);
    chk("ce_hold_dout", longint'($signed(d0_dout)), 12);
    ce = 1'b1;
    step();
    chk("ce_b_vld", longint'(d0_vld), 1);
    chk("ce_b_dout", longint'($signed(d0_dout)), 30);
    step();
    chk("ce_end_vld", longint'(d0_vld), 0);

    // reset with beats in flight
    idle(10);
    put(14'd1, 12'd2, 1'b0, 1'b1);
    put(14'd3, 12'd4, 1'b0, 1'b1);
    put(14'd5, 12'd6, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_dout", longint'(d0_dout), 0);
    chk("arst_vld", longint'(d0_vld), 0);
    idle(2);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("flush_vld", longint'(d0_vld), 0);
    end
    chk("flush_dout", longint'(d0_dout), 0);
    put(14'd1, 12'd1, 1'b0, 1'b0);
    idle(2);
    chk("post_rst_early", longint'(d0_vld), 0);
    step();
    chk("post_rst_vld", longint'(d0_vld), 1);
    chk("post_rst_dout", longint'(d0_dout), 1);

    // 16-bit accumulator overflow
`ifdef LOOP_UHAT_SPARSE_MAC_SAT_EN
    exp16     = 64'h7FFF;
    exp16_sat = 1;
`else
    exp16     = 64'h8000;
    exp16_sat = 0;
`endif
    idle(10);
    acc_mode = 1'b1;
    put(14'd217, 12'd151, 1'b1, 1'b0);
    put(14'd1, 12'd1, 1'b0, 1'b1);
    idle(2);
    chk("ovf_first", longint'(d16_dout), 64'h7FFF);
    chk("ovf_first_sat", longint'(d16_sat), 0);
    step();
    chk("ovf_dout", longint'(d16_dout), exp16);
    chk("ovf_sat", longint'(d16_sat), exp16_sat);
    chk("ovf_wide_dout", longint'(d0_dout), 32768);
    chk("ovf_wide_sat", longint'(d0_sat), 0);
    put(14'd2, 12'd3, 1'b1, 1'b1);
    idle(3);
    chk("ovf_clr_dout", longint'(d16_dout), 6);
    chk("ovf_clr_sat", longint'(d16_sat), 0);

    // signed B at minimum and maximum depth
    idle(10);
    acc_mode = 1'b0;
    put(14'd5, 12'hFFF, 1'b0, 1'b0);
    chk("s2_early", longint'(s2_vld), 0);
    step();
    chk("s2_vld", longint'(s2_vld), 1);
    chk("s2_dout", longint'($signed(s2_dout)), -5);
    chk("s8_mid", longint'(s8_vld), 0);
    idle(5);
    chk("s8_early", longint'(s8_vld), 0);
    step();
    chk("s8_vld", longint'(s8_vld), 1);
    chk("s8_dout", longint'($signed(s8_dout)), -5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
